// File: rtl/tis_fetch_pkg.sv
// Shared constants for the TIS-100 fetch stage: default geometry and redirect kinds.
package tis_fetch_pkg;

  localparam int FETCH_ADDR_W   = 8;
  localparam int FETCH_INSTR_W  = 18;
  localparam int FETCH_PROG_LEN = 26;

  localparam logic [1:0] BR_ABS = 2'b00;
  localparam logic [1:0] BR_REL = 2'b01;

endpackage : tis_fetch_pkg

// File: rtl/tis_fetch_target_calc.sv
// Combinational redirect resolution: absolute targets wrap to 0 when out of range,
// JRO targets are clamped into 0..PROG_LEN-1.
module fetch_target_calc
  import tis_fetch_pkg::*;
#(
  parameter int ADDR_W   = FETCH_ADDR_W,
  parameter int PROG_LEN = FETCH_PROG_LEN
) (
  input  logic [ADDR_W-1:0] acc_pc_i,
  input  logic [1:0]        br_kind_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic [ADDR_W-1:0] br_offset_i,
  output logic [ADDR_W-1:0] target_o,
  output logic              oor_o
);

  localparam int SUM_W = ADDR_W + 2;
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

  logic              is_rel;
  logic signed [SUM_W-1:0] rel_sum;
  logic signed [SUM_W-1:0] last_pc_s;

  assign is_rel    = (br_kind_i == BR_REL);
  assign last_pc_s = $signed({2'b00, LAST_PC});
  // Two guard bits keep acc_pc + offset exact before clamping.
  assign rel_sum   = $signed({2'b00, acc_pc_i})
                   + $signed({{2{br_offset_i[ADDR_W-1]}}, br_offset_i});
  assign oor_o     = !is_rel && (br_target_i > LAST_PC);

  always_comb begin
    target_o = '0;
    if (is_rel) begin
      if (rel_sum < 0) begin
        target_o = '0;
      end else if (rel_sum > last_pc_s) begin
        target_o = LAST_PC;
      end else begin
        target_o = rel_sum[ADDR_W-1:0];
      end
    end else if (!oor_o) begin
      target_o = br_target_i;
    end
  end

endmodule : fetch_target_calc

// File: rtl/tis_fetch_unit.sv
// TIS-100 fetch stage: drives the ROM address, holds the IR behind a valid/ready port.
// Optional sticky out-of-range jump flag when FETCH_BR_ERR_EN is defined.
module tis_fetch_unit
  import tis_fetch_pkg::*;
#(
  parameter int ADDR_W   = FETCH_ADDR_W,
  parameter int INSTR_W  = FETCH_INSTR_W,
  parameter int PROG_LEN = FETCH_PROG_LEN
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic [ADDR_W-1:0]  rom_addr_o,
  input  logic [INSTR_W-1:0] rom_data_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  input  logic               br_valid_i,
  input  logic [1:0]         br_kind_i,
  input  logic [ADDR_W-1:0]  br_target_i,
`ifdef FETCH_BR_ERR_EN
  input  logic [ADDR_W-1:0]  br_offset_i,
  output logic               br_err_o
`else
  input  logic [ADDR_W-1:0]  br_offset_i
`endif
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic [ADDR_W-1:0]  acc_pc_q, acc_pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  br_pc;
  logic               br_oor;
  logic               handshake;

  fetch_target_calc #(
    .ADDR_W   (ADDR_W),
    .PROG_LEN (PROG_LEN)
  ) u_target_calc (
    .acc_pc_i    (acc_pc_q),
    .br_kind_i   (br_kind_i),
    .br_target_i (br_target_i),
    .br_offset_i (br_offset_i),
    .target_o    (br_pc),
    .oor_o       (br_oor)
  );

  assign handshake = valid_q && instr_ready_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    instr_pc_d = instr_pc_q;
    ir_d       = ir_q;
    valid_d    = valid_q;
    acc_pc_d   = handshake ? instr_pc_q : acc_pc_q;
    // A redirect squashes the IR even if decode is accepting it this cycle.
    if (br_valid_i) begin
      fetch_pc_d = br_pc;
      valid_d    = 1'b0;
    end else if (!valid_q || instr_ready_i) begin
      ir_d       = rom_data_i;
      instr_pc_d = fetch_pc_q;
      valid_d    = 1'b1;
      fetch_pc_d = (fetch_pc_q == LAST_PC) ? '0 : fetch_pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_pc_q <= '0;
      instr_pc_q <= '0;
      acc_pc_q   <= '0;
      ir_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      instr_pc_q <= instr_pc_d;
      acc_pc_q   <= acc_pc_d;
      ir_q       <= ir_d;
      valid_q    <= valid_d;
    end
  end

  assign rom_addr_o    = fetch_pc_q;
  assign instr_o       = ir_q;
  assign instr_pc_o    = instr_pc_q;
  assign instr_valid_o = valid_q;

`ifdef FETCH_BR_ERR_EN
  logic br_err_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      br_err_q <= 1'b0;
    end else if (br_valid_i && br_oor) begin
      br_err_q <= 1'b1;
    end
  end

  assign br_err_o = br_err_q;
`else
  logic unused_br_oor;
  assign unused_br_oor = br_oor;
`endif

endmodule : tis_fetch_unit

// File: doc/tis_fetch_unit.md
# tis_fetch_unit

Instruction fetch stage for a TIS-100 node. It sits directly upstream of the program ROM: it drives the ROM's 8-bit address and latches the 18-bit instruction word the ROM returns combinationally. It presents that word to the decode/execute stage over a valid/ready handshake. It also applies sequential wrap-around, absolute jumps (JMP/JEZ/JNZ/JGZ/JLZ) and clamped relative jumps (JRO) signalled by execute.

## Interface
Parameters:
- ADDR_W, 8: ROM address width.
- INSTR_W, 18: instruction word width.
- PROG_LEN, 26: number of valid program words; legal addresses are 0..PROG_LEN-1.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; overrides every other input.
- rom_addr  out  ADDR_W  ROM read address; always equals fetch_pc.
- rom_data  in  INSTR_W  ROM read data, combinational from rom_addr.
- instr  out  INSTR_W  current instruction register (IR).
- instr_pc  out  ADDR_W  address IR was fetched from.
- instr_valid  out  1  IR holds a live instruction.
- instr_ready  in  1  decode accepts IR this cycle.
- br_valid  in  1  one-cycle redirect request from execute.
- br_kind  in  2  2'b00 absolute, 2'b01 relative (JRO); other codes are treated as absolute.
- br_target  in  ADDR_W  absolute destination.
- br_offset  in  ADDR_W  signed two's-complement JRO offset (execute saturates it to -128..127).
- br_err  out  1  only with FETCH_BR_ERR_EN; see Configuration.

## Operation
Registers:
- fetch_pc: next fetch address.
- IR, instr_pc, instr_valid.
- acc_pc: address of the last accepted instruction.

Reset values: fetch_pc=0, IR=0, instr_pc=0, instr_valid=0, acc_pc=0, br_err=0.

Per-cycle priority:
1. reset: load the reset values.
2. br_valid: fetch_pc <= resolved target; instr_valid <= 0, which squashes IR even if instr_ready=1 in the same cycle.
3. !instr_valid or instr_ready (load):
   - IR <= rom_data, instr_pc <= fetch_pc, instr_valid <= 1.
   - fetch_pc <= fetch_pc+1, or 0 when fetch_pc == PROG_LEN-1 (wrap).
4. Otherwise hold all registers; this is the stall caused by a blocked port access downstream.

Handshake rules:
- A handshake (instr_valid & instr_ready) sets acc_pc <= instr_pc. This also happens when it coincides with br_valid.
- While instr_valid=1 and instr_ready=0, instr and instr_pc stay stable.

Target resolution:
- Absolute: target = br_target. If br_target >= PROG_LEN, target = 0.
- Relative: sum = zero-extended acc_pc (pre-update value) + sign-extended br_offset, computed at ADDR_W+2 bits signed.
  - Clamp sum < 0 to 0.
  - Clamp sum > PROG_LEN-1 to PROG_LEN-1.
  - JRO 0 re-fetches the JRO itself, which is the intended infinite loop.

## Timing
- ROM read latency: 0 cycles (combinational). Fetch latency from fetch_pc to instr_valid: 1 cycle.
- Sustained throughput: one instruction per cycle while instr_ready=1.
- Redirect penalty: exactly one bubble. br_valid in cycle N gives instr_valid=0 in cycle N+1 and the target instruction valid in cycle N+2.
- First instruction after reset release: reset sampled high in cycle N gives addr 0 valid in cycle N+2.
- Reset asserted mid-stall or mid-redirect clears state in the same edge; no pending redirect survives.

## Configuration
- FETCH_BR_ERR_EN defined:
  - Port br_err exists.
  - It goes high, sticky until reset, on an absolute redirect with br_target >= PROG_LEN.
  - Target resolution is unchanged (wrap to 0).
- Undefined: the port is absent and out-of-range targets silently resolve to 0.

## Structure
- Package tis_fetch_pkg holds:
  - Default constants FETCH_ADDR_W=8, FETCH_INSTR_W=18, FETCH_PROG_LEN=26.
  - Branch kind constants BR_ABS=2'b00 and BR_REL=2'b01.
- One combinational sub-module, fetch_target_calc, takes acc_pc, br_kind, br_target and br_offset and produces the resolved target and the out-of-range flag.
- The top level holds the registers and the priority logic.

## Test plan
- Reset, then instr_ready=1 held: rom_addr steps 0,1,…,25,0. instr_pc lags rom_addr by one cycle and instr_valid=1 from the second cycle after reset.
- Stall: instr_ready=0 for 5 cycles at instr_pc=7 keeps instr, instr_pc=7 and rom_addr=8 stable. Release resumes with instr_pc=8 and no skipped or duplicated address.
- Absolute jump with br_target=3 and instr_ready=1 in the same cycle: the next cycle has instr_valid=0 and the cycle after has instr_pc=3. The squashed instruction is never re-presented.
- JRO with acc_pc=10: offset -4 gives instr_pc=6; offset -20 gives 0; offset +100 gives 25; offset 0 gives 10.
- Absolute br_target=40: resolves to 0. br_err rises and stays at 1 with FETCH_BR_ERR_EN defined, and only clears on reset.
- Reset asserted in the same cycle as br_valid (target 12): the result is the reset state, and the first valid instr_pc after release is 0.
